fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8: program-counter and instruction-address width.
REQ-002 SHALL have parameter RESET_PC, default 0: fetch address after reset.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  PC_W  request address.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid, at least 1 cycle after grant, in order.
- imem_rdata  in  8  instruction byte.
- redirect  in  1  jump/branch taken: flush and refetch.
- redirect_pc  in  PC_W  new fetch address.
- stall  in  1  decode stage cannot accept.
- out_valid  out  1  instruction presented to decoder.
- out_instr  out  8  instruction byte.
- out_pc  out  PC_W  address of out_instr.

Function
REQ-004 SHALL keep fetch_pc; each granted request SHALL increment fetch_pc by 1, wrapping modulo 2^PC_W (all-ones -> 0).
REQ-005 SHALL allow at most one outstanding memory request.
REQ-006 SHALL buffer responses in a 2-entry FIFO of {instr, pc}.
REQ-007 SHALL assert imem_req only if FIFO occupancy plus outstanding count is < 2, not halted, and redirect=0.
REQ-008 SHALL drive out_valid/out_instr/out_pc from the FIFO head; the head SHALL pop on out_valid=1 and stall=0.
REQ-009 Latency: with an empty FIFO and imem_rvalid in cycle N, out_valid SHALL be 1 in cycle N+1.
REQ-010 Simultaneous push and pop on a full FIFO SHALL keep occupancy at 2 with no loss.
REQ-011 On redirect=1: FIFO SHALL flush, fetch_pc <= redirect_pc, out_valid SHALL be 0 the next cycle, and the response to any outstanding request SHALL be discarded (1-bit epoch tag per request).
REQ-012 redirect SHALL take priority over stall, a same-cycle push, and the halt state.
REQ-013 State machine: IDLE (no outstanding) -> WAIT on grant; WAIT -> IDLE on rvalid; IDLE/WAIT -> HALTED per REQ-018; HALTED -> IDLE on redirect.
REQ-014 While in WAIT a redirect SHALL issue no new request until the stale response returns.
REQ-015 imem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-016 On rst=1: fetch_pc=RESET_PC, FIFO empty, state IDLE, epoch 0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-017 Reset mid-request SHALL drop the outstanding request; its late rvalid SHALL be ignored.

Configuration
REQ-018 Macro FETCH_HALT_STOP_EN: when defined, a pushed instruction matching 1111xxxx (HLT) SHALL move the state to HALTED and stop requests; the HLT byte SHALL still be delivered. When undefined, no HALTED state exists and fetching continues past HLT.

Structure
REQ-019 Opcode constant HLT_PREFIX (4'b1111) and the fetch-state enum SHALL live in nand_cpu_pkg.
REQ-020 The FIFO SHALL be a sub-module fetch_fifo (depth 2, push/pop/flush, full/empty).

Verification
REQ-021 Reset, 1-cycle memory, stall=0: bytes 0x10,0x21,0x32 at 0,1,2 -> out_instr 0x10/pc 0, 0x21/pc 1, 0x32/pc 2 on consecutive valid cycles.
REQ-022 stall=1 for 5 cycles -> FIFO fills to 2, imem_req=0, out_instr/out_pc held; release -> same order, no loss or duplicate.
REQ-023 redirect to 0x40 while a request is outstanding -> stale response dropped; next out_pc=0x40.
REQ-024 PC_W=8, fetch_pc=0xFF -> next request address 0x00.
REQ-025 FETCH_HALT_STOP_EN defined, byte 0xF3 at address 5 -> 0xF3/pc 5 delivered, no request to 6; redirect to 0 resumes fetching.
REQ-026 rst asserted mid-WAIT, late rvalid 0x99 -> ignored; first request after reset to RESET_PC.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: shared opcode constants, fetch-state encoding and helpers
// used by the instruction fetch path.
package nand_cpu_pkg;

    // Instruction byte width delivered by the instruction memory.
    localparam int INSTR_W = 8;

    // Upper nibble that identifies the HLT opcode (1111xxxx).
    localparam logic [3:0] HLT_PREFIX = 4'b1111;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_WAIT   = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

    // True when the instruction byte is a HLT opcode.
    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return (instr[INSTR_W-1 -: 4] == HLT_PREFIX);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry response buffer for the fetch unit. Supports push,
// pop, simultaneous push+pop when full, and a flush that empties it in one
// cycle (flush wins over push/pop).
module fetch_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [2];
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic [1:0]        count_r;
    logic              do_pop_s;
    logic              do_push_s;

    // Qualify handshakes: pop only when data exists, push when space exists
    // or the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != 2'd0);
        do_push_s = push && ((count_r != 2'd2) || do_pop_s);
        full      = (count_r == 2'd2);
        empty     = (count_r == 2'd0);
        head_data = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a 2-entry
// {instr, pc} buffer toward the decoder. Redirects flush the buffer and
// retire any in-flight response through a 1-bit epoch tag.
// Build option: FETCH_HALT_STOP_EN -- when defined, a delivered HLT opcode
// (1111xxxx) parks the fetcher in HALTED until the next redirect.
module fetch_unit
    import nand_cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [7:0]      imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [7:0]      out_instr,
    output logic [PC_W-1:0] out_pc
);

    localparam int         ENT_W   = INSTR_W + PC_W;
    localparam logic [1:0] ST_IDLE = FETCH_IDLE;
    localparam logic [1:0] ST_WAIT = FETCH_WAIT;
`ifdef FETCH_HALT_STOP_EN
    localparam logic [1:0] ST_HALTED = FETCH_HALTED;
`endif

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [PC_W-1:0]  fetch_pc_r;
    logic [PC_W-1:0]  req_pc_r;
    logic             epoch_r;
    logic             req_epoch_r;
    logic             outstanding_s;
    logic             grant_s;
    logic             resp_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [ENT_W-1:0] head_s;
`ifdef FETCH_HALT_STOP_EN
    logic             halt_s;
`endif

    assign imem_addr = fetch_pc_r;

    // Request gating, response qualification and decoder handshake.
    always_comb begin
        outstanding_s = (state_r == ST_WAIT);
        imem_req      = !rst && (state_r == ST_IDLE) && !fifo_full_s && !redirect;
        grant_s       = imem_req && imem_gnt;
        resp_s        = imem_rvalid && outstanding_s;
        push_s        = resp_s && (req_epoch_r == epoch_r) && !redirect;
        out_valid     = !fifo_empty_s;
        pop_s         = out_valid && !stall;
`ifdef FETCH_HALT_STOP_EN
        halt_s        = push_s && is_hlt(imem_rdata);
`endif
        if (out_valid) begin
            out_instr = head_s[ENT_W-1 -: 8];
            out_pc    = head_s[PC_W-1:0];
        end else begin
            out_instr = 8'h00;
            out_pc    = {PC_W{1'b0}};
        end
    end

    // Fetch state transitions; a redirect in WAIT keeps waiting for the stale reply.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (resp_s) begin
`ifdef FETCH_HALT_STOP_EN
                    if (halt_s) begin
                        state_nx_s = ST_HALTED;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
`else
                    state_nx_s = ST_IDLE;
`endif
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
`ifdef FETCH_HALT_STOP_EN
            ST_HALTED: begin
                if (redirect) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HALTED;
                end
            end
`endif
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, fetch PC and epoch bookkeeping. On redirect the in-flight tag is
    // forced to the retiring epoch so back-to-back redirects cannot revive it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fetch_pc_r  <= RESET_PC;
            req_pc_r    <= {PC_W{1'b0}};
            epoch_r     <= 1'b0;
            req_epoch_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (redirect) begin
                fetch_pc_r  <= redirect_pc;
                epoch_r     <= ~epoch_r;
                req_epoch_r <= epoch_r;
            end else if (grant_s) begin
                fetch_pc_r  <= fetch_pc_r + PC_W'(1);
                req_pc_r    <= fetch_pc_r;
                req_epoch_r <= epoch_r;
            end else begin
                fetch_pc_r  <= fetch_pc_r;
                req_epoch_r <= req_epoch_r;
            end
        end
    end

    fetch_fifo #(
        .DATA_W (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect),
        .push_data ({imem_rdata, req_pc_r}),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule
